// File: rtl/acq_trigger_scheduler_if.sv
// Trigger handshake bundle between the TTC receiver, the scheduler and the
// channel acquisition controller.
//   trig_in/trig_type_in/trig_num_in : incoming trigger strobe and payload
//   acq_ready                        : controller idle indication
//   trigger/trig_type/trig_num       : dispatch pulse and payload to controller
// master : scheduler side (consumes triggers, drives dispatch)
// slave  : environment side (TTC receiver + acquisition controller)
interface acq_trigger_scheduler_if;
  logic        trig_in;
  logic [4:0]  trig_type_in;
  logic [23:0] trig_num_in;
  logic        acq_ready;
  logic        trigger;
  logic [4:0]  trig_type;
  logic [23:0] trig_num;

  modport master (
    input  trig_in, trig_type_in, trig_num_in, acq_ready,
    output trigger, trig_type, trig_num
  );

  modport slave (
    output trig_in, trig_type_in, trig_num_in, acq_ready,
    input  trigger, trig_type, trig_num
  );
endinterface

// File: rtl/acq_trigger_scheduler.sv
// Trigger queue and dispatcher. Buffers {type, num} triggers in a small FIFO
// and hands them to the acquisition controller one at a time, with a
// programmable holdoff after each acquisition. Drops on overflow are counted.
// Ports:
//   clk, reset_n : 40 MHz TTC clock, async active-low reset
//   bus          : trigger in / dispatch out / acq_ready handshake
//   enable       : allow dispatch (queue keeps accepting while low)
//   flush        : synchronous queue clear
//   holdoff      : idle cycles required after acq_ready returns high
//   pending      : queue occupancy
//   drop_cnt     : saturating dropped-trigger count
//   overflow     : sticky, set on first drop
//   state        : one-hot FSM state
//
// state     | meaning
// ----------+------------------------------------------------------------
// IDLE      | waiting for a queued trigger, enable and acq_ready
// ISSUE     | trigger pulse high for this single cycle
// WAIT_ACK  | waiting for controller to go busy (times out after 4 cycles)
// WAIT_DONE | controller busy, waiting for acq_ready to return
// HOLDOFF   | counting holdoff cycles before the next dispatch
module acq_trigger_scheduler #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic                    clk,
  input  logic                    reset_n,
  acq_trigger_scheduler_if.master bus,
  input  logic                    enable,
  input  logic                    flush,
  input  logic [15:0]             holdoff,
  output logic [AW:0]             pending,
  output logic [15:0]             drop_cnt,
  output logic                    overflow,
  output logic [4:0]              state
);

  localparam logic [4:0] S_IDLE      = 5'b00001;
  localparam logic [4:0] S_ISSUE     = 5'b00010;
  localparam logic [4:0] S_WAIT_ACK  = 5'b00100;
  localparam logic [4:0] S_WAIT_DONE = 5'b01000;
  localparam logic [4:0] S_HOLDOFF   = 5'b10000;

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [28:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic [4:0]    state_nxt;
  logic [1:0]    ack_cnt;
  logic [15:0]   hold_cnt, hold_lim;
  logic          push, pop, drop, hold_start;

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  // ---------------- FSM: next state ----------------
  // A WAIT_ACK timeout with holdoff == 0 returns straight to IDLE, same as
  // WAIT_DONE, so a zero holdoff never means a 65536-cycle wait.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:      if (pop) state_nxt = S_ISSUE;
      S_ISSUE:     state_nxt = S_WAIT_ACK;
      S_WAIT_ACK: begin
        if (!bus.acq_ready)
          state_nxt = S_WAIT_DONE;
        else if (ack_cnt == 2'd3)
          state_nxt = (holdoff == 16'd0) ? S_IDLE : S_HOLDOFF;
      end
      S_WAIT_DONE: begin
        if (bus.acq_ready)
          state_nxt = (holdoff == 16'd0) ? S_IDLE : S_HOLDOFF;
      end
      S_HOLDOFF:   if (hold_cnt == hold_lim - 16'd1) state_nxt = S_IDLE;
      default:     state_nxt = S_IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    bus.trigger = (state == S_ISSUE);
    pop         = (state == S_IDLE) && enable && bus.acq_ready &&
                  (count != '0) && !flush;
    hold_start  = (state_nxt == S_HOLDOFF) && (state != S_HOLDOFF);
  end

  // A full queue still accepts when the head leaves on the same edge.
  assign push = bus.trig_in && !flush && ((count < FULL_CNT) || pop);
  assign drop = bus.trig_in && !flush && !push;

  assign pending = count;

  // ---------------- timers ----------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ack_cnt  <= '0;
      hold_cnt <= '0;
      hold_lim <= '0;
    end else begin
      ack_cnt <= (state == S_WAIT_ACK) ? ack_cnt + 2'd1 : 2'd0;
      if (hold_start) begin
        hold_cnt <= '0;
        hold_lim <= holdoff;
      end else if (state == S_HOLDOFF) begin
        hold_cnt <= hold_cnt + 16'd1;
      end
    end
  end

  // ---------------- queue storage ----------------
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {bus.trig_type_in, bus.trig_num_in};
  end

  // ---------------- queue control, drop accounting, dispatch payload ----------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      drop_cnt      <= '0;
      overflow      <= 1'b0;
      bus.trig_type <= '0;
      bus.trig_num  <= '0;
    end else begin
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
        case ({push, pop})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
      end
      if (drop) begin
        if (drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
        overflow <= 1'b1;
      end
      if (pop) {bus.trig_type, bus.trig_num} <= mem[rd_ptr];
    end
  end

endmodule

// File: tb/tb_acq_trigger_scheduler.sv
// Directed bench for acq_trigger_scheduler. Expected dispatches go into a
// scoreboard queue as stimulus is issued; a negedge monitor pops and compares
// each trigger pulse. Occupancy, drop accounting, state and timing are
// checked directly against hand-computed values.
module tb_acq_trigger_scheduler;
  logic        clk = 1'b0;
  logic        reset_n;
  logic        enable;
  logic        flush;
  logic [15:0] holdoff;
  logic [2:0]  pending;
  logic [15:0] drop_cnt;
  logic        overflow;
  logic [4:0]  state;

  acq_trigger_scheduler_if dif ();

  acq_trigger_scheduler #(.DEPTH(4), .AW(2)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .bus      (dif),
    .enable   (enable),
    .flush    (flush),
    .holdoff  (holdoff),
    .pending  (pending),
    .drop_cnt (drop_cnt),
    .overflow (overflow),
    .state    (state)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int trig_seen = 0;
  logic prev_trig = 1'b0;
  logic [28:0] sb[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [4:0] t, input logic [23:0] n, input bit expect_dispatch);
    dif.trig_in      = 1'b1;
    dif.trig_type_in = t;
    dif.trig_num_in  = n;
    if (expect_dispatch) sb.push_back({t, n});
    step(1);
    dif.trig_in = 1'b0;
  endtask

  task automatic wait_trig(input string nm, input int budget, output int at);
    at = -1;
    for (int i = 0; i < budget; i++) begin
      if (dif.trigger) begin
        at = cyc;
        break;
      end
      step(1);
    end
    if (at < 0) begin
      checks++;
      errors++;
      $display("FAIL %s: no trigger within %0d cycles", nm, budget);
    end
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    logic [28:0] e;
    if (reset_n) begin
      if (dif.trigger) begin
        trig_seen++;
        chk("pulse_one_cycle", {31'b0, prev_trig}, 32'd0);
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_trigger: got type %0h num %0h, none expected",
                   dif.trig_type, dif.trig_num);
        end else begin
          e = sb.pop_front();
          chk("trig_type", {27'b0, dif.trig_type}, {27'b0, e[28:24]});
          chk("trig_num", {8'b0, dif.trig_num}, {8'b0, e[23:0]});
        end
      end
      prev_trig = dif.trigger;
    end else begin
      prev_trig = 1'b0;
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int t0, at, e_rise, seen0;
    reset_n = 1'b0;
    enable = 1'b0;
    flush = 1'b0;
    holdoff = 16'd0;
    dif.trig_in = 1'b0;
    dif.trig_type_in = '0;
    dif.trig_num_in = '0;
    dif.acq_ready = 1'b0;
    step(3);
    chk("rst_state", {27'b0, state}, 32'h1);
    chk("rst_pending", {29'b0, pending}, 32'd0);
    chk("rst_drop_cnt", {16'b0, drop_cnt}, 32'd0);
    chk("rst_overflow", {31'b0, overflow}, 32'd0);
    chk("rst_trigger", {31'b0, dif.trigger}, 32'd0);
    chk("rst_trig_num", {8'b0, dif.trig_num}, 32'd0);
    reset_n = 1'b1;
    step(2);

    // Single trigger, holdoff 0
    enable = 1'b1;
    dif.acq_ready = 1'b1;
    holdoff = 16'd0;
    t0 = cyc;
    send(5'h01, 24'h000123, 1'b1);
    wait_trig("single_wait", 10, at);
    chk("single_latency", at, t0 + 2);
    dif.acq_ready = 1'b0;
    step(2);
    chk("single_wait_done", {27'b0, state}, 32'h08);
    step(8);
    dif.acq_ready = 1'b1;
    step(1);
    chk("single_idle", {27'b0, state}, 32'h01);
    chk("single_type_held", {27'b0, dif.trig_type}, 32'h01);

    // Back-to-back with holdoff 5, controller busy 8 cycles
    holdoff = 16'd5;
    dif.acq_ready = 1'b0;
    send(5'h02, 24'h000001, 1'b1);
    send(5'h02, 24'h000002, 1'b1);
    send(5'h02, 24'h000003, 1'b1);
    chk("b2b_pending3", {29'b0, pending}, 32'd3);
    dif.acq_ready = 1'b1;
    e_rise = 0;
    for (int k = 0; k < 3; k++) begin
      wait_trig("b2b_wait", 30, at);
      if (k > 0) chk("b2b_gap", at, e_rise + 6);
      chk("b2b_pending", {29'b0, pending}, 2 - k);
      dif.acq_ready = 1'b0;
      step(8);
      dif.acq_ready = 1'b1;
      e_rise = cyc + 1;
    end
    step(8);
    chk("b2b_idle", {27'b0, state}, 32'h01);

    // Overflow, then simultaneous push+pop on a full queue
    holdoff = 16'd1;
    dif.acq_ready = 1'b0;
    for (int k = 0; k < 6; k++) send(5'h04, 24'h10 + 24'(k), k < 4);
    chk("ovf_pending", {29'b0, pending}, 32'd4);
    chk("ovf_drop_cnt", {16'b0, drop_cnt}, 32'd2);
    chk("ovf_flag", {31'b0, overflow}, 32'd1);
    dif.acq_ready = 1'b1;
    send(5'h05, 24'h000016, 1'b1);
    chk("full_pushpop_pending", {29'b0, pending}, 32'd4);
    chk("full_pushpop_drop", {16'b0, drop_cnt}, 32'd2);
    for (int k = 0; k < 5; k++) begin
      wait_trig("ovf_wait", 20, at);
      dif.acq_ready = 1'b0;
      step(3);
      dif.acq_ready = 1'b1;
      step(1);
    end
    step(6);
    chk("ovf_drained", {29'b0, pending}, 32'd0);

    // Ignored triggers: acq_ready stays high, WAIT_ACK times out
    holdoff = 16'd2;
    enable = 1'b0;
    send(5'h03, 24'h000020, 1'b1);
    send(5'h03, 24'h000021, 1'b1);
    enable = 1'b1;
    wait_trig("ign_wait1", 10, t0);
    step(4);
    chk("ign_still_wait_ack", {27'b0, state}, 32'h04);
    step(1);
    chk("ign_timeout_holdoff", {27'b0, state}, 32'h10);
    wait_trig("ign_wait2", 20, at);
    chk("ign_second_latency", at, t0 + 8);
    step(12);
    chk("ign_idle", {27'b0, state}, 32'h01);
    chk("ign_pending", {29'b0, pending}, 32'd0);

    // Flush with simultaneous trig_in
    enable = 1'b0;
    send(5'h06, 24'h000030, 1'b0);
    send(5'h06, 24'h000031, 1'b0);
    send(5'h06, 24'h000032, 1'b0);
    chk("flush_pre_pending", {29'b0, pending}, 32'd3);
    flush = 1'b1;
    send(5'h06, 24'h000033, 1'b0);
    flush = 1'b0;
    chk("flush_pending", {29'b0, pending}, 32'd0);
    chk("flush_drop_cnt", {16'b0, drop_cnt}, 32'd2);
    chk("flush_overflow", {31'b0, overflow}, 32'd1);
    seen0 = trig_seen;
    enable = 1'b1;
    step(10);
    chk("flush_no_trigger", trig_seen, seen0);

    // Reset during WAIT_DONE with 2 entries pending
    enable = 1'b0;
    send(5'h07, 24'h000040, 1'b1);
    send(5'h07, 24'h000041, 1'b0);
    send(5'h07, 24'h000042, 1'b0);
    enable = 1'b1;
    wait_trig("rst_mid_wait", 10, at);
    dif.acq_ready = 1'b0;
    step(2);
    chk("mid_wait_done", {27'b0, state}, 32'h08);
    chk("mid_pending", {29'b0, pending}, 32'd2);
    #1 reset_n = 1'b0;
    #1;
    chk("mid_rst_state", {27'b0, state}, 32'h01);
    chk("mid_rst_pending", {29'b0, pending}, 32'd0);
    chk("mid_rst_trig_type", {27'b0, dif.trig_type}, 32'd0);
    chk("mid_rst_trig_num", {8'b0, dif.trig_num}, 32'd0);
    chk("mid_rst_drop_cnt", {16'b0, drop_cnt}, 32'd0);
    chk("mid_rst_overflow", {31'b0, overflow}, 32'd0);
    step(2);
    reset_n = 1'b1;
    dif.acq_ready = 1'b1;
    seen0 = trig_seen;
    step(10);
    chk("post_rst_no_trigger", trig_seen, seen0);
    chk("post_rst_pending", {29'b0, pending}, 32'd0);

    chk("scoreboard_empty", sb.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
